exc_ctrl: RTL

//  Exception/interrupt sequencer that sits directly upstream of coprocessor 0 (cop).

---
 rtl/exc_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer in front of cop: arbitrates eret/break/syscall/irq,
// drains the pipe, issues one cop op, then redirects the PC. Option: EXC_CTRL_IRQ_MASK_EN.
module exc_ctrl #(
  parameter int IRQ_W        = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_W-1:0] irq,
  input  logic             status_ie,
  input  logic             status_exl,
  input  logic             sys_req,
  input  logic             brk_req,
  input  logic             eret_req,
  input  logic [19:0]      code_in,
  input  logic [31:0]      epc_in,
  input  logic             irq_mask_wr,
  input  logic [IRQ_W-1:0] irq_mask_data,
  output logic             stall,
  output logic             flush,
  output logic [3:0]       cop_op,
  output logic [19:0]      cop_code,
  output logic [31:0]      cop_next_pc,
  output logic             redirect_valid,
  output logic [IRQ_W-1:0] irq_ack
);

  localparam logic [3:0] COP_OP_NOP = 4'h0;
  localparam logic [3:0] COP_OP_SYS = 4'h1;
  localparam logic [3:0] COP_OP_BRK = 4'h2;
  localparam logic [3:0] COP_OP_RET = 4'h3;
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ISSUE, S_REDIR} state_t;
  typedef enum logic [1:0] {K_SYS, K_BRK, K_RET, K_IRQ} kind_t;

  state_t             state_q, state_d;
  kind_t              kind_q, kind_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IRQ_W-1:0]   pend_q, pend_d;
  logic [19:0]        code_q, code_d;
  logic [31:0]        epc_q, epc_d;
  logic [4:0]         idx_q, idx_d;
  logic               flush_q, flush_d;
  logic [3:0]         cop_op_q, cop_op_d;
  logic [19:0]        cop_code_q, cop_code_d;
  logic [31:0]        cop_next_pc_q, cop_next_pc_d;
  logic               redirect_q, redirect_d;
  logic [IRQ_W-1:0]   irq_ack_q, irq_ack_d;
  logic [IRQ_W-1:0]   mask_s;
  logic               irq_ok_s;
  logic               accept_s;

  function automatic logic [4:0] lowest_idx(input logic [IRQ_W-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (v[i]) idx = i[4:0];
    end
    return idx;
  endfunction

`ifdef EXC_CTRL_IRQ_MASK_EN
  logic [IRQ_W-1:0] mask_q, mask_d;

  always_comb begin
    if (irq_mask_wr) mask_d = irq_mask_data;
    else             mask_d = mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) mask_q <= {IRQ_W{1'b1}};
    else     mask_q <= mask_d;
  end

  assign mask_s = mask_q;
`else
  logic unused_mask_s;
  assign mask_s        = {IRQ_W{1'b1}};
  assign unused_mask_s = ^{irq_mask_wr, irq_mask_data};
`endif

  assign irq_ok_s = status_ie & ~status_exl & (|(pend_q & mask_s));

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    cnt_d         = cnt_q;
    code_d        = code_q;
    epc_d         = epc_q;
    idx_d         = idx_q;
    pend_d        = pend_q | irq;
    accept_s      = 1'b0;
    cop_op_d      = COP_OP_NOP;
    cop_code_d    = 20'h0;
    cop_next_pc_d = 32'h0;
    irq_ack_d     = {IRQ_W{1'b0}};

    case (state_q)
      S_IDLE: begin
        if (eret_req || brk_req || sys_req || irq_ok_s) begin
          accept_s = 1'b1;
          code_d   = code_in;
          epc_d    = epc_in;
          idx_d    = lowest_idx(pend_q & mask_s);
          if (eret_req) begin
            kind_d = K_RET;
            epc_d  = 32'h0;
          end else if (brk_req) begin
            kind_d = K_BRK;
          end else if (sys_req) begin
            kind_d = K_SYS;
          end else begin
            kind_d = K_IRQ;
          end
          if (FLUSH_CYCLES == 0) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_DRAIN;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (cnt_q == {CNT_W{1'b0}}) state_d = S_ISSUE;
        else                        cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      S_ISSUE: state_d = S_REDIR;
      S_REDIR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    flush_d    = (state_d == S_DRAIN) || (state_d == S_ISSUE);
    redirect_d = (state_d == S_REDIR);
    if (state_d == S_ISSUE) begin
      cop_next_pc_d = epc_d;
      cop_code_d    = code_d;
      case (kind_d)
        K_RET:   cop_op_d = COP_OP_RET;
        K_BRK:   cop_op_d = COP_OP_BRK;
        K_SYS:   cop_op_d = COP_OP_SYS;
        K_IRQ: begin
          cop_op_d   = COP_OP_SYS;
          cop_code_d = {15'h7FFF, idx_d};
          irq_ack_d  = {{(IRQ_W-1){1'b0}}, 1'b1} << idx_d;
          pend_d     = pend_d & ~irq_ack_d;
        end
        default: cop_op_d = COP_OP_NOP;
      endcase
    end else begin
      cop_op_d = COP_OP_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      kind_q        <= K_SYS;
      cnt_q         <= {CNT_W{1'b0}};
      pend_q        <= {IRQ_W{1'b0}};
      code_q        <= 20'h0;
      epc_q         <= 32'h0;
      idx_q         <= 5'd0;
      flush_q       <= 1'b0;
      cop_op_q      <= COP_OP_NOP;
      cop_code_q    <= 20'h0;
      cop_next_pc_q <= 32'h0;
      redirect_q    <= 1'b0;
      irq_ack_q     <= {IRQ_W{1'b0}};
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      code_q        <= code_d;
      epc_q         <= epc_d;
      idx_q         <= idx_d;
      flush_q       <= flush_d;
      cop_op_q      <= cop_op_d;
      cop_code_q    <= cop_code_d;
      cop_next_pc_q <= cop_next_pc_d;
      redirect_q    <= redirect_d;
      irq_ack_q     <= irq_ack_d;
    end
  end

  // stall must cover the accept cycle itself, hence combinational.
  assign stall          = (state_q != S_IDLE) || accept_s;
  assign flush          = flush_q;
  assign cop_op         = cop_op_q;
  assign cop_code       = cop_code_q;
  assign cop_next_pc    = cop_next_pc_q;
  assign redirect_valid = redirect_q;
  assign irq_ack        = irq_ack_q;

endmodule
